// File: rtl/parking_gate_ctrl_if.sv
// Request/status bundle between the car-park lane logic and the barrier gate controller.
interface parking_gate_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             enter_grant;
  logic             exit_req;
  logic             car_through;
  logic             gate_open;
  logic             gate_dir;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             entry_reject;
  logic             timeout;
  logic             busy;
  logic [15:0]      stat_entries;
  logic [15:0]      stat_rejects;

  modport master (
    output enter_grant, exit_req, car_through,
    input  gate_open, gate_dir, occupancy, full, empty,
    input  entry_reject, timeout, busy, stat_entries, stat_rejects
  );

  modport slave (
    input  enter_grant, exit_req, car_through,
    output gate_open, gate_dir, occupancy, full, empty,
    output entry_reject, timeout, busy, stat_entries, stat_rejects
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Shared barrier gate sequencer with occupancy tracking and one-deep per-direction request queuing.
// Optional entry/reject statistics counters are built when PARKING_STATS_EN is defined.
module parking_gate_ctrl #(
  parameter int CAPACITY          = 8,
  parameter int CNT_W             = 4,
  parameter int GATE_OPEN_CYCLES  = 16,
  parameter int GATE_CLOSE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  parking_gate_ctrl_if.slave   bus
);

  localparam int TMR_MAX = (GATE_OPEN_CYCLES > GATE_CLOSE_CYCLES) ? GATE_OPEN_CYCLES : GATE_CLOSE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LOAD = TMR_W'(GATE_CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSING} state_t;

  state_t            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [CNT_W-1:0]  occ_q;
  logic              full_q, empty_q;
  logic              gate_open_q, gate_dir_q, busy_q;
  logic              reject_q, timeout_q;
  logic              pend_in_q, pend_out_q;

  // Bit 0 = enter_grant, bit 1 = exit_req, bit 2 = car_through.
  logic [2:0] in_q, in_prev_q;
  logic [2:0] edge_d;
  logic       enter_edge, exit_edge, car_edge;
  logic       exit_cand_d, entry_cand_d, reject_d, pass_in_d;
  logic [CNT_W-1:0] occ_pass_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q      <= '0;
      in_prev_q <= '0;
    end else begin
      in_q      <= {bus.car_through, bus.exit_req, bus.enter_grant};
      in_prev_q <= in_q;
    end
  end

  assign edge_d     = in_q & ~in_prev_q;
  assign enter_edge = edge_d[0];
  assign exit_edge  = edge_d[1];
  assign car_edge   = edge_d[2];

  assign exit_cand_d  = exit_edge | pend_out_q;
  assign entry_cand_d = enter_edge | pend_in_q;
  assign reject_d     = (state_q == IDLE) && !exit_cand_d && entry_cand_d && full_q;
  assign pass_in_d    = (state_q == OPEN_IN) && car_edge;
  assign occ_pass_d   = (state_q == OPEN_IN) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      gate_open_q <= 1'b0;
      gate_dir_q  <= 1'b0;
      busy_q      <= 1'b0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
      pend_in_q   <= 1'b0;
      pend_out_q  <= 1'b0;
    end else begin
      reject_q  <= reject_d;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (exit_cand_d) begin
            pend_out_q <= 1'b0;
            // An entry edge arriving with the serviced exit waits its turn.
            if (enter_edge) pend_in_q <= 1'b1;
            if (!empty_q) begin
              state_q     <= OPEN_OUT;
              gate_open_q <= 1'b1;
              gate_dir_q  <= 1'b0;
              busy_q      <= 1'b1;
              timer_q     <= OPEN_LOAD;
            end
          end else if (entry_cand_d) begin
            pend_in_q <= 1'b0;
            if (!full_q) begin
              state_q     <= OPEN_IN;
              gate_open_q <= 1'b1;
              gate_dir_q  <= 1'b1;
              busy_q      <= 1'b1;
              timer_q     <= OPEN_LOAD;
            end
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (car_edge || timer_q == '0) begin
            state_q     <= CLOSING;
            gate_open_q <= 1'b0;
            timer_q     <= CLOSE_LOAD;
            if (car_edge) begin
              occ_q   <= occ_pass_d;
              full_q  <= (occ_pass_d == CAP);
              empty_q <= (occ_pass_d == '0);
            end else begin
              timeout_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        CLOSING: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (state_q != IDLE) begin
        if (enter_edge) pend_in_q  <= 1'b1;
        if (exit_edge)  pend_out_q <= 1'b1;
      end
    end
  end

`ifdef PARKING_STATS_EN
  logic [15:0] stat_entries_q, stat_rejects_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_entries_q <= '0;
      stat_rejects_q <= '0;
    end else begin
      if (pass_in_d && stat_entries_q != 16'hFFFF) stat_entries_q <= stat_entries_q + 16'd1;
      if (reject_d  && stat_rejects_q != 16'hFFFF) stat_rejects_q <= stat_rejects_q + 16'd1;
    end
  end

  assign bus.stat_entries = stat_entries_q;
  assign bus.stat_rejects = stat_rejects_q;
`else
  logic unused_stat_d;
  assign unused_stat_d    = pass_in_d;
  assign bus.stat_entries = 16'd0;
  assign bus.stat_rejects = 16'd0;
`endif

  assign bus.gate_open    = gate_open_q;
  assign bus.gate_dir     = gate_dir_q;
  assign bus.occupancy    = occ_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.entry_reject = reject_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed scoreboard bench for parking_gate_ctrl at default parameters.
module tb_parking_gate_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  parking_gate_ctrl_if #(.CNT_W(4)) bus ();

  parking_gate_ctrl #(
    .CAPACITY(8), .CNT_W(4), .GATE_OPEN_CYCLES(16), .GATE_CLOSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

`ifdef PARKING_STATS_EN
  localparam int EXP_ENTRIES = 8;
  localparam int EXP_REJECTS = 1;
`else
  localparam int EXP_ENTRIES = 0;
  localparam int EXP_REJECTS = 0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%0d expected=<queued value>", obs);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_open(input string tag);
    int n = 0;
    while (bus.gate_open !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_now(tag, 32'(bus.gate_open), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check_now(tag, 32'(bus.busy), 0);
  endtask

  task automatic do_pass(input bit dir_in, input int exp_occ);
    if (dir_in) bus.enter_grant = 1'b1;
    else        bus.exit_req    = 1'b1;
    expect_v("pass_dir", 32'(dir_in));
    expect_v("pass_occ", 32'(exp_occ));
    wait_open("pass_open");
    pop_check(32'(bus.gate_dir));
    tick();
    bus.car_through = 1'b1;
    tick();
    bus.car_through = 1'b0;
    bus.enter_grant = 1'b0;
    bus.exit_req    = 1'b0;
    wait_idle("pass_idle");
    pop_check(32'(bus.occupancy));
    $display("pass dir=%0d occupancy=%0d full=%0d empty=%0d", dir_in, bus.occupancy, bus.full, bus.empty);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, lo, gap, opens;
    bus.enter_grant = 1'b0;
    bus.exit_req    = 1'b0;
    bus.car_through = 1'b0;

    // Reset state
    repeat (5) tick();
    check_now("rst_gate_open", 32'(bus.gate_open), 0);
    check_now("rst_gate_dir",  32'(bus.gate_dir), 0);
    check_now("rst_occupancy", 32'(bus.occupancy), 0);
    check_now("rst_full",      32'(bus.full), 0);
    check_now("rst_empty",     32'(bus.empty), 1);
    check_now("rst_reject",    32'(bus.entry_reject), 0);
    check_now("rst_timeout",   32'(bus.timeout), 0);
    check_now("rst_busy",      32'(bus.busy), 0);
    check_now("rst_stat_ent",  32'(bus.stat_entries), 0);
    check_now("rst_stat_rej",  32'(bus.stat_rejects), 0);
    $display("reset released");
    reset_n = 1'b1;
    tick();

    // Basic entry with exact latencies
    bus.enter_grant = 1'b1;
    expect_v("lat_edge_n", 0);
    expect_v("lat_edge_n1", 1);
    expect_v("entry_dir", 1);
    tick();
    pop_check(32'(bus.gate_open));
    tick();
    pop_check(32'(bus.gate_open));
    pop_check(32'(bus.gate_dir));
    repeat (2) tick();
    bus.car_through = 1'b1;
    expect_v("open_before_pass", 1);
    expect_v("closed_after_pass", 0);
    expect_v("occ_after_pass", 1);
    expect_v("empty_after_pass", 0);
    tick();
    bus.car_through = 1'b0;
    pop_check(32'(bus.gate_open));
    tick();
    pop_check(32'(bus.gate_open));
    pop_check(32'(bus.occupancy));
    pop_check(32'(bus.empty));
    expect_v("busy_closing", 1);
    expect_v("busy_clear", 0);
    repeat (3) tick();
    pop_check(32'(bus.busy));
    tick();
    pop_check(32'(bus.busy));
    bus.enter_grant = 1'b0;
    tick();
    $display("basic entry occupancy=%0d", bus.occupancy);

    // Fill the lot, then a refused entry
    for (int k = 2; k <= 8; k++) do_pass(1'b1, k);
    check_now("full_at_cap", 32'(bus.full), 1);
    bus.enter_grant = 1'b1;
    expect_v("reject_pulse", 1);
    expect_v("reject_gate_closed", 0);
    expect_v("reject_not_busy", 0);
    expect_v("reject_single", 0);
    expect_v("reject_gate_stays", 0);
    tick();
    tick();
    pop_check(32'(bus.entry_reject));
    pop_check(32'(bus.gate_open));
    pop_check(32'(bus.busy));
    tick();
    pop_check(32'(bus.entry_reject));
    repeat (3) tick();
    pop_check(32'(bus.gate_open));
    bus.enter_grant = 1'b0;
    tick();
    check_now("stat_entries", 32'(bus.stat_entries), EXP_ENTRIES);
    check_now("stat_rejects", 32'(bus.stat_rejects), EXP_REJECTS);
    $display("reject at full stat_entries=%0d stat_rejects=%0d", bus.stat_entries, bus.stat_rejects);

    // Timeout window
    do_pass(1'b0, 7);
    check_now("not_full_after_exit", 32'(bus.full), 0);
    bus.enter_grant = 1'b1;
    tick();
    tick();
    hi = 0;
    while (bus.gate_open === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    check_now("timeout_open_len", 32'(hi), 16);
    check_now("timeout_pulse", 32'(bus.timeout), 1);
    lo = 0;
    while (bus.busy === 1'b1 && lo < 40) begin
      lo++;
      tick();
    end
    check_now("timeout_close_len", 32'(lo), 4);
    check_now("timeout_pulse_end", 32'(bus.timeout), 0);
    check_now("timeout_occ", 32'(bus.occupancy), 7);
    bus.enter_grant = 1'b0;
    tick();
    $display("timeout open=%0d closed=%0d occupancy=%0d", hi, lo, bus.occupancy);

    // Simultaneous requests: exit first, queued entry after the close gap
    for (int k = 6; k >= 2; k--) do_pass(1'b0, k);
    bus.enter_grant = 1'b1;
    bus.exit_req    = 1'b1;
    expect_v("prio_open", 1);
    expect_v("prio_dir_out", 0);
    expect_v("prio_occ_out", 1);
    expect_v("prio_gap", 5);
    expect_v("prio_dir_in", 1);
    expect_v("prio_occ_in", 2);
    tick();
    tick();
    pop_check(32'(bus.gate_open));
    pop_check(32'(bus.gate_dir));
    tick();
    bus.car_through = 1'b1;
    tick();
    bus.car_through = 1'b0;
    bus.enter_grant = 1'b0;
    bus.exit_req    = 1'b0;
    tick();
    pop_check(32'(bus.occupancy));
    gap = 0;
    while (bus.gate_open !== 1'b1 && gap < 40) begin
      gap++;
      tick();
    end
    pop_check(32'(gap));
    pop_check(32'(bus.gate_dir));
    tick();
    bus.car_through = 1'b1;
    tick();
    bus.car_through = 1'b0;
    wait_idle("prio_idle");
    pop_check(32'(bus.occupancy));
    $display("priority gap=%0d occupancy=%0d", gap, bus.occupancy);

    // Exit on empty lot is discarded
    do_pass(1'b0, 1);
    do_pass(1'b0, 0);
    check_now("empty_flag", 32'(bus.empty), 1);
    bus.exit_req = 1'b1;
    repeat (4) tick();
    check_now("empty_exit_gate", 32'(bus.gate_open), 0);
    check_now("empty_exit_busy", 32'(bus.busy), 0);
    check_now("empty_exit_occ", 32'(bus.occupancy), 0);
    bus.exit_req = 1'b0;
    tick();
    $display("exit on empty discarded occupancy=%0d", bus.occupancy);

    // Second entry edge while pend_in is already set is dropped
    bus.enter_grant = 1'b1;
    wait_open("ovf_first_open");
    bus.enter_grant = 1'b0;
    tick();
    bus.enter_grant = 1'b1;
    tick();
    bus.enter_grant = 1'b0;
    tick();
    bus.enter_grant = 1'b1;
    tick();
    bus.enter_grant = 1'b0;
    repeat (2) tick();
    bus.car_through = 1'b1;
    tick();
    bus.car_through = 1'b0;
    wait_idle("ovf_first_idle");
    check_now("ovf_occ1", 32'(bus.occupancy), 1);
    wait_open("ovf_pending_open");
    check_now("ovf_pending_dir", 32'(bus.gate_dir), 1);
    tick();
    bus.car_through = 1'b1;
    tick();
    bus.car_through = 1'b0;
    wait_idle("ovf_second_idle");
    check_now("ovf_occ2", 32'(bus.occupancy), 2);
    opens = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.gate_open === 1'b1) opens++;
    end
    check_now("ovf_no_third_open", 32'(opens), 0);
    $display("overflow request dropped occupancy=%0d", bus.occupancy);

    // Asynchronous reset while the gate is open
    bus.enter_grant = 1'b1;
    wait_open("rst_mid_open");
    #2;
    reset_n = 1'b0;
    #1;
    check_now("rst_mid_gate", 32'(bus.gate_open), 0);
    check_now("rst_mid_occ", 32'(bus.occupancy), 0);
    check_now("rst_mid_empty", 32'(bus.empty), 1);
    check_now("rst_mid_busy", 32'(bus.busy), 0);
    bus.enter_grant = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    $display("mid-operation reset occupancy=%0d", bus.occupancy);

    check_now("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
